c910_axi_throttle: RTL

Transaction throttle and isolation controller placed between the C910 AXI master port (after burst unwrapping) and the SoC interconnect. It caps outstanding read and write transactions per direction, and sequences a clean drain-and-isolate handshake so software or the power controller can quiesce the core's bus port without truncating bursts. All channels pass through combinationally; the block only gates AR/AW/W valid/ready.

---
 rtl/c910_axi_pkg.sv | 48 ++++
 rtl/c910_axi_txn_counter.sv | 46 ++++
 rtl/c910_axi_throttle.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/c910_axi_pkg.sv
// rtl/c910_axi_pkg.sv - shared types and constants for the C910 AXI throttle
//
// Holds the throttle FSM state type, the transaction/stall counter widths and
// the default flattened AXI request/response structs used by the top level.

package c910_axi_pkg;

    localparam int CntWidth      = 8;
    localparam int StallCntWidth = 32;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        DRAIN    = 2'd1,
        ISOLATED = 2'd2
    } throttle_state_e;

    typedef struct packed {
        logic [3:0]  ar_id;
        logic [31:0] ar_addr;
        logic [7:0]  ar_len;
        logic        ar_valid;
        logic [3:0]  aw_id;
        logic [31:0] aw_addr;
        logic [7:0]  aw_len;
        logic        aw_valid;
        logic [63:0] w_data;
        logic [7:0]  w_strb;
        logic        w_last;
        logic        w_valid;
        logic        r_ready;
        logic        b_ready;
    } axi_req_s;

    typedef struct packed {
        logic        ar_ready;
        logic        aw_ready;
        logic        w_ready;
        logic [3:0]  r_id;
        logic [63:0] r_data;
        logic [1:0]  r_resp;
        logic        r_last;
        logic        r_valid;
        logic [3:0]  b_id;
        logic [1:0]  b_resp;
        logic        b_valid;
    } axi_rsp_s;

endpackage

// File: rtl/c910_axi_txn_counter.sv
// rtl/c910_axi_txn_counter.sv - saturating up/down outstanding-transaction counter
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   inc, dec     count up / count down this cycle (both together = no change)
//   limit        threshold for the full flag
//   count        registered count
//   full         count >= limit
//   empty        count == 0

module c910_axi_txn_counter
    import c910_axi_pkg::*;
#(
    parameter int Width = CntWidth
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    input  logic [Width-1:0] limit,
    output logic [Width-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [Width-1:0] cnt_q;

    // Both ends saturate: a decrement at zero is a protocol error and is
    // flagged by the assertion below rather than wrapping the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (inc && !dec) begin
            if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
        end else if (dec && !inc) begin
            if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
        end
    end

    assign count = cnt_q;
    assign full  = (cnt_q >= limit);
    assign empty = (cnt_q == '0);

    underflow_chk: assert property (@(posedge clk) disable iff (rst) !(dec && !inc && empty));

endmodule

// File: rtl/c910_axi_throttle.sv
// rtl/c910_axi_throttle.sv - outstanding-transaction throttle and drain/isolate controller
//
// Sits between the C910 AXI master port and the interconnect. All channels
// pass through combinationally; only AR/AW/W valid and ready are gated.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   slv_req_i/slv_rsp_o   C910 side request/response
//   mst_req_o/mst_rsp_i   interconnect side request/response
//   isolate_i             level request to drain and block the port
//   isolated_o            port drained and blocked
//   rd_outstanding_o      outstanding reads (AR accepted, final R not yet)
//   wr_outstanding_o      outstanding writes (AW accepted, B not yet)
//   ar_stall_cnt_o        cycles an AR was held by the throttle
//   aw_stall_cnt_o        cycles an AW was held by the throttle
//
// Build option: C910_AXI_THROTTLE_STATS_EN enables the saturating stall
// counters; without it both stall outputs are constant zero.

module c910_axi_throttle
    import c910_axi_pkg::*;
#(
    parameter int  MaxReadTxns  = 16,
    parameter int  MaxWriteTxns = 16,
    parameter type axi_req_t    = axi_req_s,
    parameter type axi_rsp_t    = axi_rsp_s
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  axi_req_t                 slv_req_i,
    output axi_rsp_t                 slv_rsp_o,
    output axi_req_t                 mst_req_o,
    input  axi_rsp_t                 mst_rsp_i,
    input  logic                     isolate_i,
    output logic                     isolated_o,
    output logic [CntWidth-1:0]      rd_outstanding_o,
    output logic [CntWidth-1:0]      wr_outstanding_o,
    output logic [StallCntWidth-1:0] ar_stall_cnt_o,
    output logic [StallCntWidth-1:0] aw_stall_cnt_o
);

    localparam logic [CntWidth-1:0] RdLimit = CntWidth'(MaxReadTxns);
    localparam logic [CntWidth-1:0] WrLimit = CntWidth'(MaxWriteTxns);

    throttle_state_e state_q, state_d;
    logic ar_committed_q, aw_committed_q;

    logic rd_full, rd_empty, wr_full, wr_empty, wp_full, wp_empty;
    logic [CntWidth-1:0] rd_count, wr_count, wp_count;

    logic ar_open, aw_open, w_open;
    logic mst_ar_valid, mst_aw_valid, mst_w_valid;
    logic ar_hs, aw_hs, w_last_hs, r_last_hs, b_hs;
    logic drained;

    // A committed request stays open whatever the gate does, so an AR/AW
    // that was already presented downstream is never withdrawn.
    assign ar_open = ar_committed_q || (state_q == RUN && !rd_full);
    assign aw_open = aw_committed_q || (state_q == RUN && !wr_full && !wp_full);

    assign mst_ar_valid = slv_req_i.ar_valid && ar_open;
    assign mst_aw_valid = slv_req_i.aw_valid && aw_open;

    assign ar_hs = mst_ar_valid && mst_rsp_i.ar_ready;
    assign aw_hs = mst_aw_valid && mst_rsp_i.aw_ready;

    // W only flows for a write whose address is already accepted, or is
    // being accepted right now.
    assign w_open      = !wp_empty || aw_hs;
    assign mst_w_valid = slv_req_i.w_valid && w_open;

    assign w_last_hs = mst_w_valid && mst_rsp_i.w_ready && slv_req_i.w_last;
    assign r_last_hs = mst_rsp_i.r_valid && slv_req_i.r_ready && mst_rsp_i.r_last;
    assign b_hs      = mst_rsp_i.b_valid && slv_req_i.b_ready;

    always_comb begin
        mst_req_o          = slv_req_i;
        mst_req_o.ar_valid = mst_ar_valid;
        mst_req_o.aw_valid = mst_aw_valid;
        mst_req_o.w_valid  = mst_w_valid;

        slv_rsp_o          = mst_rsp_i;
        slv_rsp_o.ar_ready = mst_rsp_i.ar_ready && ar_open;
        slv_rsp_o.aw_ready = mst_rsp_i.aw_ready && aw_open;
        slv_rsp_o.w_ready  = mst_rsp_i.w_ready && w_open;
    end

    c910_axi_txn_counter #(.Width(CntWidth)) u_rd_cnt (
        .clk   (clk_i),
        .rst   (rst_i),
        .inc   (ar_hs),
        .dec   (r_last_hs),
        .limit (RdLimit),
        .count (rd_count),
        .full  (rd_full),
        .empty (rd_empty)
    );

    c910_axi_txn_counter #(.Width(CntWidth)) u_wr_cnt (
        .clk   (clk_i),
        .rst   (rst_i),
        .inc   (aw_hs),
        .dec   (b_hs),
        .limit (WrLimit),
        .count (wr_count),
        .full  (wr_full),
        .empty (wr_empty)
    );

    // Write-data debt: addresses accepted whose last W beat has not passed.
    c910_axi_txn_counter #(.Width(CntWidth)) u_wp_cnt (
        .clk   (clk_i),
        .rst   (rst_i),
        .inc   (aw_hs),
        .dec   (w_last_hs),
        .limit ('1),
        .count (wp_count),
        .full  (wp_full),
        .empty (wp_empty)
    );

    assign drained = rd_empty && wr_empty && (wp_count == '0)
                     && !ar_committed_q && !aw_committed_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= RUN;
            ar_committed_q <= 1'b0;
            aw_committed_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            ar_committed_q <= mst_ar_valid && !mst_rsp_i.ar_ready;
            aw_committed_q <= mst_aw_valid && !mst_rsp_i.aw_ready;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (isolate_i) state_d = DRAIN;
            end
            DRAIN: begin
                if (!isolate_i)   state_d = RUN;
                else if (drained) state_d = ISOLATED;
            end
            ISOLATED: begin
                if (!isolate_i) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    assign isolated_o       = (state_q == ISOLATED);
    assign rd_outstanding_o = rd_count;
    assign wr_outstanding_o = wr_count;

`ifdef C910_AXI_THROTTLE_STATS_EN
    logic [StallCntWidth-1:0] ar_stall_q, aw_stall_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ar_stall_q <= '0;
            aw_stall_q <= '0;
        end else begin
            if (slv_req_i.ar_valid && !ar_open && ar_stall_q != '1)
                ar_stall_q <= ar_stall_q + 1'b1;
            if (slv_req_i.aw_valid && !aw_open && aw_stall_q != '1)
                aw_stall_q <= aw_stall_q + 1'b1;
        end
    end

    assign ar_stall_cnt_o = ar_stall_q;
    assign aw_stall_cnt_o = aw_stall_q;
`else
    assign ar_stall_cnt_o = '0;
    assign aw_stall_cnt_o = '0;
`endif

endmodule
